// File: rtl/riscv151_mmio_pkg.sv
// Shared MMIO constants, register decode and TX handshake state for the
// Riscv151 uart memory-mapped responder.
package riscv151_mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam int          RX_DATA_W = 8;

  // Register offsets inside the decoded window (addr[1:0] ignored).
  localparam logic [7:0] UART_CTRL = 8'h00;
  localparam logic [7:0] UART_RX   = 8'h04;
  localparam logic [7:0] UART_TX   = 8'h08;
  localparam logic [7:0] CYC_CNT   = 8'h10;
  localparam logic [7:0] INST_CNT  = 8'h14;
  localparam logic [7:0] CNT_RST   = 8'h18;

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_RX      = 3'd1,
    REG_TX      = 3'd2,
    REG_CYC     = 3'd3,
    REG_INST    = 3'd4,
    REG_CNT_RST = 3'd5,
    REG_NONE    = 3'd6
  } mmio_reg_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  // Map a window offset to the register it selects; word aligned.
  function automatic mmio_reg_e decode_offset(input logic [7:0] offset);
    mmio_reg_e sel;
    case ({offset[7:2], 2'b00})
      UART_CTRL: sel = REG_CTRL;
      UART_RX:   sel = REG_RX;
      UART_TX:   sel = REG_TX;
      CYC_CNT:   sel = REG_CYC;
      INST_CNT:  sel = REG_INST;
      CNT_RST:   sel = REG_CNT_RST;
      default:   sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// Small synchronous FIFO buffering uart RX bytes until the CPU reads them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mmio_rx_fifo
  import riscv151_mmio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [RX_DATA_W-1:0] wr_data,
  input  logic                 rd_en,
  output logic                 full,
  output logic                 empty,
  output logic [RX_DATA_W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [RX_DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]          wr_ptr_r;
  logic [AW:0]          rd_ptr_r;
  logic                 push_s;
  logic                 pop_s;

  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_s = wr_en & ~full;
  assign pop_s  = rd_en & ~empty;
  assign dout   = mem_r[rd_ptr_r[AW-1:0]];

  // Advance write/read pointers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Store an accepted byte; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// CPU-facing MMIO responder for the on-chip uart: status/RX/TX registers,
// cycle and retired-instruction counters, registered read data.
module uart_mmio_responder #(
  parameter int          RX_FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE     = riscv151_mmio_pkg::MMIO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_en,
  input  logic [3:0]  mmio_we,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_din,
  output logic [31:0] mmio_dout,
  input  logic        inst_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  import riscv151_mmio_pkg::*;

  logic        sel_s;
  logic        rd_s;
  logic        wr_s;
  mmio_reg_e   reg_s;
  logic        cnt_clr_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        fifo_push_s;
  logic        fifo_pop_s;
  logic [7:0]  fifo_head_s;
  logic [31:0] rdata_s;
  logic [31:0] cycle_cnt_r;
  logic [31:0] instr_cnt_r;
  logic [31:0] dout_r;
  tx_state_e   tx_state_r;
  tx_state_e   tx_state_next_s;
  logic        tx_load_s;
  logic [7:0]  tx_data_r;
  logic        unused_bits_s;

  assign unused_bits_s = ^{mmio_din[31:8], mmio_addr[1:0]};

  assign sel_s     = mmio_en & (mmio_addr[31:8] == MMIO_BASE[31:8]);
  assign rd_s      = sel_s & ~(|mmio_we);
  assign wr_s      = sel_s & (|mmio_we);
  assign reg_s     = decode_offset(mmio_addr[7:0]);
  assign cnt_clr_s = wr_s & (reg_s == REG_CNT_RST);

  // RX side: uart is held off while in reset or while the FIFO is full.
  assign uart_rx_ready = rst & ~fifo_full_s;
  assign fifo_push_s   = uart_rx_valid & uart_rx_ready;
  assign fifo_pop_s    = rd_s & (reg_s == REG_RX) & ~fifo_empty_s;

  assign uart_tx_valid = (tx_state_r == TX_BUSY);
  assign uart_tx_data  = tx_data_r;
  assign mmio_dout     = dout_r;

  mmio_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_push_s),
    .wr_data (uart_rx_data),
    .rd_en   (fifo_pop_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .dout    (fifo_head_s)
  );

  // Read-data mux; an empty RX read returns zero and pops nothing.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (reg_s)
      REG_CTRL: rdata_s = {30'd0, ~fifo_empty_s, ~uart_tx_valid};
      REG_RX: begin
        if (fifo_empty_s) begin
          rdata_s = 32'h0000_0000;
        end else begin
          rdata_s = {24'd0, fifo_head_s};
        end
      end
      REG_CYC:  rdata_s = cycle_cnt_r;
      REG_INST: rdata_s = instr_cnt_r;
      default:  rdata_s = 32'h0000_0000;
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_r <= 32'h0000_0000;
    end else if (rd_s) begin
      dout_r <= rdata_s;
    end
  end

  // Free-running counters; a clear write beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr_s) begin
      cycle_cnt_r <= 32'h0000_0000;
      instr_cnt_r <= 32'h0000_0000;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
      if (inst_retire) begin
        instr_cnt_r <= instr_cnt_r + 32'd1;
      end
    end
  end

  // TX handshake state register; reset abandons any pending byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_r <= TX_IDLE;
    end else begin
      tx_state_r <= tx_state_next_s;
    end
  end

  // TX next state: load only when idle, release on valid&ready.
  always_comb begin
    tx_state_next_s = tx_state_r;
    tx_load_s       = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (wr_s && (reg_s == REG_TX)) begin
          tx_state_next_s = TX_BUSY;
          tx_load_s       = 1'b1;
        end else begin
          tx_state_next_s = TX_IDLE;
        end
      end
      TX_BUSY: begin
        if (uart_tx_ready) begin
          tx_state_next_s = TX_IDLE;
        end else begin
          tx_state_next_s = TX_BUSY;
        end
      end
      default: tx_state_next_s = TX_IDLE;
    endcase
  end

  // TX holding register; stays stable while the byte is pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_data_r <= 8'h00;
    end else if (tx_load_s) begin
      tx_data_r <= mmio_din[7:0];
    end
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Self-checking bench for uart_mmio_responder: directed vector table,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_uart_mmio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_en;
  logic [3:0]  mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_din;
  logic [31:0] mmio_dout;
  logic        inst_retire;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  always #5 clk = ~clk;

  uart_mmio_responder dut (
    .clk           (clk),
    .rst           (rst),
    .mmio_en       (mmio_en),
    .mmio_we       (mmio_we),
    .mmio_addr     (mmio_addr),
    .mmio_din      (mmio_din),
    .mmio_dout     (mmio_dout),
    .inst_retire   (inst_retire),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_dout;
  logic [31:0] m_cyc;
  logic [31:0] m_inst;
  logic        m_txv;
  logic [7:0]  m_txd;
  logic [7:0]  m_q[$];
  logic [7:0]  src[$];
  logic [7:0]  tx_log[$];
  bit          m_rx_acc;

  logic [7:0] off_tbl [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic        ret;
    logic        txr;
    logic        push;
    logic [7:0]  rxd;
    logic [31:0] e_dout;
    logic        e_txv;
    logic [7:0]  e_txd;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic [3:0] we, input logic [31:0] addr,
                              input logic [31:0] din, input logic ret, input logic txr,
                              input logic push, input logic [7:0] rxd,
                              input logic [31:0] ed, input logic etv, input logic [7:0] etd);
    vec_t v;
    v.we = we; v.addr = addr; v.din = din; v.ret = ret; v.txr = txr;
    v.push = push; v.rxd = rxd; v.e_dout = ed; v.e_txv = etv; v.e_txd = etd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of the register-map behaviour, from the pre-edge inputs.
  function automatic void model_edge();
    bit         sel;
    bit         rd;
    bit         wr;
    bit         pop;
    logic [7:0] off;
    if (!rst) begin
      m_dout = 32'd0; m_txv = 1'b0; m_txd = 8'd0; m_cyc = 32'd0; m_inst = 32'd0;
      m_q.delete();
      m_rx_acc = 1'b0;
      return;
    end
    sel = mmio_en && (mmio_addr[31:8] == 24'h80_0000);
    rd  = sel && (mmio_we == 4'h0);
    wr  = sel && (mmio_we != 4'h0);
    off = {mmio_addr[7:2], 2'b00};
    m_rx_acc = uart_rx_valid && (m_q.size() < 8);
    pop = 1'b0;
    if (rd) begin
      case (off)
        8'h00: m_dout = {30'd0, (m_q.size() != 0), !m_txv};
        8'h04: begin
          if (m_q.size() != 0) begin
            m_dout = {24'd0, m_q[0]};
            pop = 1'b1;
          end else begin
            m_dout = 32'd0;
          end
        end
        8'h10:   m_dout = m_cyc;
        8'h14:   m_dout = m_inst;
        default: m_dout = 32'd0;
      endcase
    end
    if (pop) void'(m_q.pop_front());
    if (m_rx_acc) m_q.push_back(uart_rx_data);
    if (m_txv) begin
      if (uart_tx_ready) m_txv = 1'b0;
    end else if (wr && off == 8'h08) begin
      m_txv = 1'b1;
      m_txd = mmio_din[7:0];
    end
    if (wr && off == 8'h18) begin
      m_cyc = 32'd0;
      m_inst = 32'd0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      if (inst_retire) m_inst = m_inst + 32'd1;
    end
  endfunction

  task automatic step();
    uart_rx_valid = (src.size() != 0);
    uart_rx_data  = (src.size() != 0) ? src[0] : 8'h00;
    #1;
    if (rst && uart_tx_valid && uart_tx_ready) tx_log.push_back(uart_tx_data);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (m_rx_acc) void'(src.pop_front());
    check("dout", mmio_dout, m_dout);
    check("tx_valid", {31'd0, uart_tx_valid}, {31'd0, m_txv});
    check("tx_data", {24'd0, uart_tx_data}, {24'd0, m_txd});
    check("rx_ready", {31'd0, uart_rx_ready}, {31'd0, (rst && (m_q.size() < 8))});
  endtask

  task automatic acc(input logic [3:0] we, input logic [7:0] off, input logic [31:0] din);
    mmio_en = 1'b1; mmio_we = we; mmio_addr = 32'h8000_0000 | {24'd0, off}; mmio_din = din;
    step();
    mmio_en = 1'b0; mmio_we = 4'h0;
  endtask

  task automatic rd_reg(input logic [7:0] off, input string name, input logic [31:0] exp);
    acc(4'h0, off, 32'd0);
    check(name, mmio_dout, exp);
  endtask

  initial begin
    int need;
    rst = 1'b0; mmio_en = 1'b0; mmio_we = 4'h0; mmio_addr = 32'd0; mmio_din = 32'd0;
    inst_retire = 1'b0; uart_tx_ready = 1'b0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;
    m_dout = 32'd0; m_cyc = 32'd0; m_inst = 32'd0; m_txv = 1'b0; m_txd = 8'd0; m_rx_acc = 1'b0;

    tbl[0]  = mk(4'h0, 32'h8000_0000, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h1, 1'b0, 8'h00);
    tbl[1]  = mk(4'hF, 32'h8000_0008, 32'h41,        1'b0, 1'b0, 1'b0, 8'h00, 32'h1, 1'b1, 8'h41);
    tbl[2]  = mk(4'h0, 32'h8000_0000, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 8'h41);
    tbl[3]  = mk(4'h1, 32'h8000_0008, 32'h42,        1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 8'h41);
    tbl[4]  = mk(4'h0, 32'h8000_0010, 32'h0,         1'b0, 1'b1, 1'b0, 8'h00, 32'h4, 1'b0, 8'h41);
    tbl[5]  = mk(4'h0, 32'h8000_0000, 32'h0,         1'b0, 1'b0, 1'b1, 8'h5A, 32'h1, 1'b0, 8'h41);
    tbl[6]  = mk(4'h0, 32'h8000_0003, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h3, 1'b0, 8'h41);
    tbl[7]  = mk(4'h0, 32'h8000_0004, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h5A, 1'b0, 8'h41);
    tbl[8]  = mk(4'h0, 32'h8000_0004, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h41);
    tbl[9]  = mk(4'h0, 32'h8000_0014, 32'h0,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h41);
    tbl[10] = mk(4'h0, 32'h8000_0016, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h1, 1'b0, 8'h41);
    tbl[11] = mk(4'h8, 32'h8000_0018, 32'h0,         1'b1, 1'b0, 1'b0, 8'h00, 32'h1, 1'b0, 8'h41);
    tbl[12] = mk(4'h0, 32'h8000_0010, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h41);
    tbl[13] = mk(4'h0, 32'h8000_0014, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h41);
    tbl[14] = mk(4'h0, 32'h8000_0010, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h2, 1'b0, 8'h41);
    tbl[15] = mk(4'h0, 32'h9000_0010, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h2, 1'b0, 8'h41);
    tbl[16] = mk(4'h0, 32'h8000_000C, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h41);
    tbl[17] = mk(4'hF, 32'h8000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h41);
    tbl[18] = mk(4'h0, 32'h8000_0010, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h6, 1'b0, 8'h41);

    @(negedge clk);
    repeat (3) step();
    check("reset_dout", mmio_dout, 32'd0);
    check("reset_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
    check("reset_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      mmio_en = 1'b1; mmio_we = tbl[i].we; mmio_addr = tbl[i].addr; mmio_din = tbl[i].din;
      inst_retire = tbl[i].ret; uart_tx_ready = tbl[i].txr;
      if (tbl[i].push) src.push_back(tbl[i].rxd);
      step();
      check("vec_dout", mmio_dout, tbl[i].e_dout);
      check("vec_tx_valid", {31'd0, uart_tx_valid}, {31'd0, tbl[i].e_txv});
      check("vec_tx_data", {24'd0, uart_tx_data}, {24'd0, tbl[i].e_txd});
      mmio_en = 1'b0; mmio_we = 4'h0; inst_retire = 1'b0; uart_tx_ready = 1'b0;
    end

    // TX hold and busy drop
    tx_log.delete();
    acc(4'hF, 8'h08, 32'h41);
    acc(4'hF, 8'h08, 32'h42);
    repeat (3) step();
    check("tx_hold_valid", {31'd0, uart_tx_valid}, 32'd1);
    check("tx_hold_data", {24'd0, uart_tx_data}, 32'h41);
    rd_reg(8'h00, "tx_busy_status", 32'h0);
    uart_tx_ready = 1'b1;
    step();
    uart_tx_ready = 1'b0;
    check("tx_done_valid", {31'd0, uart_tx_valid}, 32'd0);
    rd_reg(8'h00, "tx_idle_status", 32'h1);
    check("tx_count", tx_log.size(), 32'd1);
    if (tx_log.size() != 0) check("tx_byte", {24'd0, tx_log[0]}, 32'h41);

    // RX FIFO fill, backpressure and drain
    for (int b = 0; b < 9; b++) src.push_back(8'(8'h10 + b));
    repeat (10) step();
    check("fifo_full_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
    rd_reg(8'h00, "fifo_full_status", 32'h3);
    for (int b = 0; b < 9; b++) rd_reg(8'h04, "fifo_order", 32'(8'h10 + b));
    rd_reg(8'h04, "fifo_empty_read", 32'h0);
    rd_reg(8'h00, "fifo_drained_status", 32'h1);

    // Counters: 100 cycles, exactly 40 retire pulses at random positions
    acc(4'h2, 8'h18, 32'h0);
    need = 40;
    for (int c = 0; c < 100; c++) begin
      inst_retire = ($urandom_range(99 - c, 0) < need);
      if (inst_retire) need--;
      step();
    end
    inst_retire = 1'b0;
    rd_reg(8'h10, "cyc_100", 32'd100);
    rd_reg(8'h14, "inst_40", 32'd40);
    acc(4'hF, 8'h18, 32'h0);
    rd_reg(8'h10, "cyc_cleared", 32'd0);
    rd_reg(8'h14, "inst_cleared", 32'd0);

    // Wrap and clear/increment collision
    force dut.cycle_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt_r;
    m_cyc = 32'hFFFF_FFFF;
    rd_reg(8'h10, "cyc_pre_wrap", 32'hFFFF_FFFF);
    rd_reg(8'h10, "cyc_wrapped", 32'h0);
    inst_retire = 1'b1;
    step();
    acc(4'hF, 8'h18, 32'h0);
    inst_retire = 1'b0;
    rd_reg(8'h14, "clear_beats_retire", 32'h0);

    // Reset during TX and with bytes queued
    acc(4'hF, 8'h08, 32'h5A);
    src.push_back(8'hA1); src.push_back(8'hA2); src.push_back(8'hA3);
    repeat (4) step();
    rd_reg(8'h00, "pre_reset_status", 32'h2);
    rst = 1'b0;
    step();
    check("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
    check("rst_dout", mmio_dout, 32'd0);
    check("rst_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
    step();
    rst = 1'b1;
    #1;
    check("rx_ready_after_release", {31'd0, uart_rx_ready}, 32'd1);
    rd_reg(8'h00, "post_reset_status", 32'h1);
    rd_reg(8'h04, "post_reset_rx_empty", 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(299, 0) != 0);
      mmio_en = 1'($urandom_range(1, 0));
      mmio_we = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 1));
      mmio_addr = (($urandom_range(15, 0) == 0) ? 32'h8000_0100 : 32'h8000_0000)
                  | {24'd0, off_tbl[$urandom_range(7, 0)]} | 32'($urandom_range(3, 0));
      mmio_din = $urandom;
      inst_retire = 1'($urandom_range(1, 0));
      uart_tx_ready = ($urandom_range(3, 0) == 0);
      if (src.size() < 3 && $urandom_range(2, 0) == 0) src.push_back(8'($urandom));
      step();
    end
    rst = 1'b1; mmio_en = 1'b0; mmio_we = 4'h0; inst_retire = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
